// File: rtl/psram_burst_arbiter_if.sv
// psram_burst_arbiter_if
// Bundles the write port, read port and memory-controller signals of the PSRAM
// burst arbiter so they can be passed as a single port.
//   slave  : arbiter view (requests/memory responses in, grants/commands out)
//   master : environment view (requesters plus memory controller)
// clk and resetb are deliberately not part of the bundle.
interface psram_burst_arbiter_if #(
    parameter int ADDR_W = 21
);
    logic              calib_done;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_grant;
    logic [31:0]       wr_wdata;
    logic [3:0]        wr_wmask;     // 1 = skip byte
    logic              wr_wready;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_grant;
    logic [31:0]       rd_rdata;
    logic              rd_rvalid;
    logic              rd_done;

    logic              mem_cmd;      // 1 = write, 0 = read
    logic              mem_cmd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;

    logic              rd_timeout_err;

    modport slave (
        input  calib_done,
        input  wr_req, wr_addr, wr_wdata, wr_wmask,
        input  rd_req, rd_addr,
        input  mem_rdata, mem_rvalid,
        output wr_grant, wr_wready,
        output rd_grant, rd_rdata, rd_rvalid, rd_done,
        output mem_cmd, mem_cmd_en, mem_addr, mem_wdata, mem_wmask,
        output rd_timeout_err
    );

    modport master (
        output calib_done,
        output wr_req, wr_addr, wr_wdata, wr_wmask,
        output rd_req, rd_addr,
        output mem_rdata, mem_rvalid,
        input  wr_grant, wr_wready,
        input  rd_grant, rd_rdata, rd_rvalid, rd_done,
        input  mem_cmd, mem_cmd_en, mem_addr, mem_wdata, mem_wmask,
        input  rd_timeout_err
    );
endinterface

// File: rtl/psram_burst_arbiter.sv
// psram_burst_arbiter
// Arbitrates one burst-write port and one burst-read port onto a PSRAM
// controller command interface. Round-robin between ports, fixed-length bursts,
// enforced idle gap between bursts, and a sticky timeout for reads whose data
// never arrives.
// Ports:
//   clk    : clock
//   resetb : asynchronous active-low reset
//   bus    : psram_burst_arbiter_if.slave (requesters + memory controller)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// INIT_WAIT | controller not calibrated, requests ignored
// IDLE      | arbitrate; grant pulses here, address latched
// WR_BURST  | BURST_BEATS write beats, command issued on the first one
// RD_CMD    | single read command cycle
// RD_WAIT   | waiting for first read beat, timeout armed
// RD_DATA   | receiving remaining read beats, gaps allowed
// GAP       | CMD_GAP idle cycles before the next arbitration
module psram_burst_arbiter #(
    parameter int ADDR_W      = 21,
    parameter int BURST_BEATS = 8,
    parameter int CMD_GAP     = 4,
    parameter int RD_TIMEOUT  = 64
) (
    input  logic                 clk,
    input  logic                 resetb,
    psram_burst_arbiter_if.slave bus
);
    localparam int BEAT_W  = $clog2(BURST_BEATS) + 1;
    localparam int TMR_MAX = (RD_TIMEOUT > CMD_GAP) ? RD_TIMEOUT : CMD_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);
    localparam logic [TMR_W-1:0]  GAP_LOAD  = TMR_W'(CMD_GAP - 1);
    localparam logic [TMR_W-1:0]  TMO_LOAD  = TMR_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        INIT_WAIT, IDLE, WR_BURST, RD_CMD, RD_WAIT, RD_DATA, GAP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    // Shared down-counter: read timeout in RD_WAIT, idle gap in GAP.
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    // 1 = write wins a tie (last served was a read, or fresh out of reset).
    logic              prio_wr_q, prio_wr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              done_q, done_d;
    logic              tmo_err_q, tmo_err_d;

    logic grant_wr, grant_rd, beat_in;

    assign grant_wr = (state_q == IDLE) && bus.calib_done && bus.wr_req
                      && (!bus.rd_req || prio_wr_q);
    assign grant_rd = (state_q == IDLE) && bus.calib_done && bus.rd_req
                      && (!bus.wr_req || !prio_wr_q);
    // Read data is only accepted while a read burst is actually open.
    assign beat_in  = bus.mem_rvalid && ((state_q == RD_WAIT) || (state_q == RD_DATA));

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= INIT_WAIT;
            addr_q    <= '0;
            beat_q    <= '0;
            tmr_q     <= '0;
            prio_wr_q <= 1'b1;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            tmr_q     <= tmr_d;
            prio_wr_q <= prio_wr_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            done_q    <= done_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        tmr_d     = tmr_q;
        prio_wr_d = prio_wr_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        done_d    = 1'b0;
        tmo_err_d = tmo_err_q;

        if (beat_in) begin
            rdata_d  = bus.mem_rdata;
            rvalid_d = 1'b1;
            beat_d   = beat_q + 1'b1;
        end

        unique case (state_q)
            INIT_WAIT: begin
                if (bus.calib_done) state_d = IDLE;
            end
            IDLE: begin
                if (!bus.calib_done) begin
                    state_d = INIT_WAIT;
                end else if (grant_wr) begin
                    state_d   = WR_BURST;
                    addr_d    = bus.wr_addr;
                    beat_d    = '0;
                    prio_wr_d = 1'b0;
                end else if (grant_rd) begin
                    state_d   = RD_CMD;
                    addr_d    = bus.rd_addr;
                    beat_d    = '0;
                    prio_wr_d = 1'b1;
                end
            end
            WR_BURST: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = GAP;
                    tmr_d   = GAP_LOAD;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            RD_CMD: begin
                state_d = RD_WAIT;
                tmr_d   = TMO_LOAD;
            end
            RD_WAIT: begin
                if (beat_in) begin
                    if (beat_q == LAST_BEAT) begin
                        done_d  = 1'b1;
                        state_d = GAP;
                        tmr_d   = GAP_LOAD;
                    end else begin
                        state_d = RD_DATA;
                    end
                end else if (tmr_q == '0) begin
                    // Give up: flag it, close the transaction with an empty done.
                    tmo_err_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = GAP;
                    tmr_d     = GAP_LOAD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            RD_DATA: begin
                if (beat_in && (beat_q == LAST_BEAT)) begin
                    done_d  = 1'b1;
                    state_d = GAP;
                    tmr_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (tmr_q == '0) state_d = IDLE;
                else             tmr_d   = tmr_q - 1'b1;
            end
            default: state_d = INIT_WAIT;
        endcase
    end

    always_comb begin
        bus.wr_grant       = grant_wr;
        bus.rd_grant       = grant_rd;
        bus.wr_wready      = (state_q == WR_BURST);
        bus.mem_wdata      = (state_q == WR_BURST) ? bus.wr_wdata : 32'd0;
        bus.mem_wmask      = (state_q == WR_BURST) ? bus.wr_wmask : 4'd0;
        bus.mem_cmd        = (state_q == WR_BURST) && (beat_q == '0);
        bus.mem_cmd_en     = ((state_q == WR_BURST) && (beat_q == '0)) || (state_q == RD_CMD);
        bus.mem_addr       = bus.mem_cmd_en ? addr_q : '0;
        bus.rd_rdata       = rdata_q;
        bus.rd_rvalid      = rvalid_q;
        bus.rd_done        = done_q;
        bus.rd_timeout_err = tmo_err_q;
    end
endmodule
